tug_game_ctrl: RTL and testbench
================================

# tug_game_ctrl

Game controller that produces the `led_control` and `score` pair consumed by the LED output multiplexer in the tug-of-war design. It detects presses from the two players and the start button and tracks the rope-marker position as a one-hot 7-bit vector. It runs the IDLE/PLAY/WIN sequence and flashes the winning LED pattern by toggling `led_control`. It sits between the debounced button inputs and the LED mux.

## Interface
Parameters:
- `FLASH_DIV`, default 25_000_000: clk cycles per half-period of the win flash; legal range ≥ 2.
- `CNT_W`, default 25: width of the flash counter; must satisfy 2^CNT_W ≥ FLASH_DIV.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start/restart button; already synchronised and debounced, level.
- `pbl`  in  1  left-player button; already synchronised and debounced, level.
- `pbr`  in  1  right-player button; already synchronised and debounced, level.
- `led_control`  out  2  mux select: 00 = blank, 01 = play display, 10 = win display.
- `score`  out  7  one-hot marker position; bit 6 = left end, bit 0 = right end.
- `winner`  out  2  00 = none, 10 = left player won, 01 = right player won.

## Operation
- **Edge detection.** One delay register each for `start`, `pbl` and `pbr`. A press is `x & ~x_d`.
  - Delay registers reset to 1, so a button held through reset does not register.
  - A held button produces exactly one press.
- **Position.** A 3-bit register `pos` (0..6); `score = 1 << pos` whenever `score` is non-zero.
- **State IDLE** (reset state):
  - Outputs: `led_control` = 00, `score` = 0, `winner` = 00.
  - `pbl`/`pbr` presses are ignored.
  - A `start` press sets `pos` = 3 and goes to PLAY.
- **State PLAY:**
  - Outputs: `led_control` = 01, `score` = `1 << pos`, `winner` = 00.
  - `pbl` press alone: `pos` +1. `pbr` press alone: `pos` −1.
  - Both pressed in the same cycle: no move.
  - If a move makes `pos` = 6, go to WIN_L. If a move makes `pos` = 0, go to WIN_R.
  - A `start` press re-centres: `pos` = 3, stay in PLAY. A `start` press takes priority over player presses in the same cycle.
- **States WIN_L / WIN_R:**
  - `pos` is frozen; `winner` = 10 (WIN_L) or 01 (WIN_R).
  - `pbl`/`pbr` presses are ignored.
  - Flash behaviour:
    - A counter runs 0..FLASH_DIV−1 and wraps.
    - At wrap, the `flash` bit toggles.
    - `led_control` = 10 when `flash` = 1, 00 when `flash` = 0.
    - `score` remains `1 << pos` throughout.
  - A `start` press goes to PLAY with `pos` = 3, `winner` = 00.
- **Reset mid-operation.** Asserting `rst_n` low forces IDLE with all outputs 0 immediately, regardless of state.

## Timing
- All outputs are registered. Reset values: `led_control` = 00, `score` = 0000000, `winner` = 00.
- **Press latency.** A press is first sampled at clk edge N. The corresponding `score`/`led_control`/`winner` change is visible after edge N+1: one cycle for edge detection plus one register.
- **Win transition.** The move that reaches an end updates `score` to 1000000 or 0000001 in the same cycle that `led_control` becomes 10 and `winner` is set.
- **Entering WIN.** Counter = 0 and `flash` = 1. `led_control` is 10 for exactly FLASH_DIV cycles, then 00 for FLASH_DIV cycles, repeating.
- **Leaving WIN.** On a `start` press the counter and `flash` are cleared, and `led_control` = 01 from the next cycle.
- **Asynchronous reset.** Deassertion of `rst_n` is assumed synchronous to `clk` at the system level. The first press can be accepted on the second edge after deassertion.

## Test plan
- **Reset behaviour.** Hold `rst_n` = 0, then release. Pulse `pbl` and `pbr` with no `start` → `led_control` = 00, `score` = 0000000, `winner` = 00 throughout.
- **Left win.** Pulse `start` → `led_control` = 01, `score` = 0001000. Pulse `pbl` three times → `score` goes 0010000, then 0100000, then 1000000. On the third press `led_control` = 10 and `winner` = 10.
- **Hold and simultaneous press.** In PLAY at center, hold `pbr` high for 10 cycles → exactly one move (`score` = 0000100). Raise `pbl` and `pbr` in the same cycle → `score` unchanged.
- **Flash timing.** With FLASH_DIV = 4, reach WIN_R → `led_control` = 10 for 4 cycles, 00 for 4, 10 for 4. `score` = 0000001 and `winner` = 01 constant. Further `pbl` presses are ignored.
- **Restart and start priority.** In WIN_R, pulse `start` → `led_control` = 01, `score` = 0001000, `winner` = 00. In PLAY at `pos` = 5, pulse `start` and `pbl` together → `score` = 0001000, no win.
- **Mid-game reset.** Drop `rst_n` asynchronously between clk edges while in PLAY → all outputs 0 before the next edge. After release, the FSM is in IDLE.

Source files
------------

// File: rtl/tug_game_ctrl_if.sv
// Button/LED bundle between the debounced inputs, the game controller and the LED mux.
// Ports: start/pbl/pbr are level button inputs. led_control (mux select), score (one-hot marker)
//        and winner are the controller outputs.
// master drives the buttons and observes the outputs. slave is the controller side.
interface tug_game_ctrl_if;
  logic       start;
  logic       pbl;
  logic       pbr;
  logic [1:0] led_control;
  logic [6:0] score;
  logic [1:0] winner;

  modport master (
    output start, pbl, pbr,
    input  led_control, score, winner
  );

  modport slave (
    input  start, pbl, pbr,
    output led_control, score, winner
  );
endinterface

// File: rtl/tug_game_ctrl.sv
// Tug-of-war game controller: press detection, IDLE/PLAY/WIN sequencing, marker position, win flash.
// Latency: a press sampled at edge N is visible on the registered outputs after edge N+1.
// No backpressure. Presses are consumed the cycle they are detected. Presses that do not apply in the current state are dropped.
// Ports: clk, rst_n (async, active-low). bus.slave carries start/pbl/pbr in and led_control/score/winner out.
module tug_game_ctrl #(
  parameter int unsigned FLASH_DIV = 25_000_000,
  parameter int unsigned CNT_W     = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  tug_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_WIN_L = 2'd2,
    S_WIN_R = 2'd3
  } state_t;

  localparam logic [2:0]       POS_CENTER = 3'd3;
  localparam logic [2:0]       POS_LEFT   = 3'd6;
  localparam logic [2:0]       POS_RIGHT  = 3'd0;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FLASH_DIV - 1);

  // Press detection. The delay registers reset high, so a button held
  // through reset must be released and pressed again before it counts.
  logic start_d, pbl_d, pbr_d;
  logic start_p, pbl_p, pbr_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d <= 1'b1;
      pbl_d   <= 1'b1;
      pbr_d   <= 1'b1;
      start_p <= 1'b0;
      pbl_p   <= 1'b0;
      pbr_p   <= 1'b0;
    end else begin
      start_d <= bus.start;
      pbl_d   <= bus.pbl;
      pbr_d   <= bus.pbr;
      start_p <= bus.start & ~start_d;
      pbl_p   <= bus.pbl & ~pbl_d;
      pbr_p   <= bus.pbr & ~pbr_d;
    end
  end

  state_t           state, state_nxt;
  logic [2:0]       pos, pos_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flash, flash_nxt;

  logic [1:0] led_q, led_nxt;
  logic [6:0] score_q, score_nxt;
  logic [1:0] winner_q, winner_nxt;

  // State register, including the position and flash datapath it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pos   <= POS_CENTER;
      cnt   <= '0;
      flash <= 1'b0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      cnt   <= cnt_nxt;
      flash <= flash_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    cnt_nxt   = cnt;
    flash_nxt = flash;
    unique case (state)
      S_IDLE: begin
        if (start_p) begin
          state_nxt = S_PLAY;
          pos_nxt   = POS_CENTER;
        end
      end
      S_PLAY: begin
        // start outranks any player press in the same cycle.
        if (start_p) begin
          pos_nxt = POS_CENTER;
        end else if (pbl_p && !pbr_p) begin
          pos_nxt = pos + 3'd1;
          if (pos + 3'd1 == POS_LEFT) begin
            state_nxt = S_WIN_L;
            cnt_nxt   = '0;
            flash_nxt = 1'b1;
          end
        end else if (pbr_p && !pbl_p) begin
          pos_nxt = pos - 3'd1;
          if (pos - 3'd1 == POS_RIGHT) begin
            state_nxt = S_WIN_R;
            cnt_nxt   = '0;
            flash_nxt = 1'b1;
          end
        end
      end
      S_WIN_L, S_WIN_R: begin
        if (start_p) begin
          state_nxt = S_PLAY;
          pos_nxt   = POS_CENTER;
          cnt_nxt   = '0;
          flash_nxt = 1'b0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          flash_nxt = ~flash;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode. It works from the next-state values so the output registers
  // change on the same edge as the state they describe.
  always_comb begin
    led_nxt    = 2'b00;
    score_nxt  = 7'b0000000;
    winner_nxt = 2'b00;
    unique case (state_nxt)
      S_PLAY: begin
        led_nxt   = 2'b01;
        score_nxt = 7'b0000001 << pos_nxt;
      end
      S_WIN_L: begin
        led_nxt    = flash_nxt ? 2'b10 : 2'b00;
        score_nxt  = 7'b0000001 << pos_nxt;
        winner_nxt = 2'b10;
      end
      S_WIN_R: begin
        led_nxt    = flash_nxt ? 2'b10 : 2'b00;
        score_nxt  = 7'b0000001 << pos_nxt;
        winner_nxt = 2'b01;
      end
      default: begin
        led_nxt    = 2'b00;
        score_nxt  = 7'b0000000;
        winner_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= 2'b00;
      score_q  <= 7'b0000000;
      winner_q <= 2'b00;
    end else begin
      led_q    <= led_nxt;
      score_q  <= score_nxt;
      winner_q <= winner_nxt;
    end
  end

  assign bus.led_control = led_q;
  assign bus.score       = score_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Self-checking bench for tug_game_ctrl using directed scenarios plus random button levels.
// The reference model tracks game mode, marker position, pending presses and time spent in a win state.
module tb_tug_game_ctrl;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tug_game_ctrl_if bus ();

  tug_game_ctrl #(.FLASH_DIV(FD), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Modes: 0 idle, 1 play, 2 left won, 3 right won.
  int m_mode, m_pos, m_wt;
  bit pend_s, pend_l, pend_r;
  bit prev_s, prev_l, prev_r;

  task automatic model_reset();
    m_mode = 0; m_pos = 3; m_wt = 0;
    pend_s = 0; pend_l = 0; pend_r = 0;
    prev_s = 1; prev_l = 1; prev_r = 1;
  endtask

  task automatic model_step();
    if (pend_s) begin
      m_mode = 1; m_pos = 3; m_wt = 0;
    end else if (m_mode == 1 && (pend_l != pend_r)) begin
      m_pos = pend_l ? m_pos + 1 : m_pos - 1;
      if (m_pos == 6) begin m_mode = 2; m_wt = 0; end
      if (m_pos == 0) begin m_mode = 3; m_wt = 0; end
    end else if (m_mode >= 2) begin
      m_wt++;
    end
    pend_s = bus.start & ~prev_s;
    pend_l = bus.pbl & ~prev_l;
    pend_r = bus.pbr & ~prev_r;
    prev_s = bus.start; prev_l = bus.pbl; prev_r = bus.pbr;
  endtask

  function automatic int exp_led();
    if (m_mode == 0) return 0;
    if (m_mode == 1) return 1;
    return (((m_wt / FD) % 2) == 0) ? 2 : 0;
  endfunction

  function automatic int exp_score();
    return (m_mode == 0) ? 0 : (1 << m_pos);
  endfunction

  function automatic int exp_winner();
    return (m_mode == 2) ? 2 : (m_mode == 3) ? 1 : 0;
  endfunction

  // One clock: drive levels, let the edge happen, then compare at the falling edge.
  task automatic cyc(input logic s, input logic l, input logic r);
    bus.start = s; bus.pbl = l; bus.pbr = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led_control", int'(bus.led_control), exp_led());
    check("score", int'(bus.score), exp_score());
    check("winner", int'(bus.winner), exp_winner());
  endtask

  task automatic pulse(input logic s, input logic l, input logic r);
    cyc(s, l, r);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  logic rs, rl, rr;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pbl = 1'b0; bus.pbr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_led", int'(bus.led_control), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_winner", int'(bus.winner), 0);
    rst_n = 1'b1;

    // Player presses in IDLE do nothing.
    cyc(0, 0, 0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    check("idle_score", int'(bus.score), 0);

    // Start, then a left win. The output follows one cycle after the press is sampled.
    cyc(1, 0, 0);
    check("start_latency", int'(bus.score), 0);
    cyc(0, 0, 0);
    check("start_score", int'(bus.score), 7'b0001000);
    pulse(0, 1, 0);
    check("left1", int'(bus.score), 7'b0010000);
    pulse(0, 1, 0);
    check("left2", int'(bus.score), 7'b0100000);
    pulse(0, 1, 0);
    check("left3", int'(bus.score), 7'b1000000);
    check("left_led", int'(bus.led_control), 2);
    check("left_winner", int'(bus.winner), 2);

    // Restart from the win, then hold pbr: exactly one move. A simultaneous press does not move.
    pulse(1, 0, 0);
    repeat (10) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("hold_once", int'(bus.score), 7'b0000100);
    pulse(0, 1, 1);
    check("both_nomove", int'(bus.score), 7'b0000100);

    // Reach WIN_R and watch the flash: 10 for FD cycles, then 00 for FD, and so on.
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    check("winr_score", int'(bus.score), 7'b0000001);
    check("winr_led0", int'(bus.led_control), 2);
    for (int k = 1; k < 12; k++) begin
      cyc(0, (k == 3 || k == 7), 0);
      check("flash", int'(bus.led_control), (((k / FD) % 2) == 0) ? 2 : 0);
      check("flash_score", int'(bus.score), 7'b0000001);
      check("flash_winner", int'(bus.winner), 1);
    end

    // Restart from WIN_R. Then start outranks a pbl press at pos 5.
    pulse(1, 0, 0);
    check("restart_led", int'(bus.led_control), 1);
    check("restart_score", int'(bus.score), 7'b0001000);
    check("restart_winner", int'(bus.winner), 0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    check("pos5", int'(bus.score), 7'b0100000);
    pulse(1, 1, 0);
    check("prio_score", int'(bus.score), 7'b0001000);
    check("prio_winner", int'(bus.winner), 0);

    // Asynchronous reset between edges while playing.
    @(posedge clk);
    #1;
    check("pre_rst_led", int'(bus.led_control), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_led", int'(bus.led_control), 0);
    check("async_score", int'(bus.score), 0);
    check("async_winner", int'(bus.winner), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    pulse(0, 1, 0);
    check("post_rst_idle", int'(bus.led_control), 0);

    // Random button levels checked against the model every cycle.
    rs = 1'b0; rl = 1'b0; rr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) rs = ~rs;
      if ($urandom_range(2) == 0) rl = ~rl;
      if ($urandom_range(2) == 0) rr = ~rr;
      cyc(rs, rl, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
